match_controller: RTL and testbench
===================================

# match_controller

Game-flow controller for the two-player pong design. It consumes the per-frame goal and paddle-hit events from the collision detection stage and tracks score and rally length. It sequences serve, play, point and game-over, and drives the ball stage's reset/enable and serve direction. It sits directly downstream of collision detection and upstream of the ball, feeding that loop from the top level.

## Interface
- SCORE_WIDTH, 4: width of each player's score.
- WIN_SCORE, 7: score that ends the match; must be 1..2^SCORE_WIDTH-1.
- SERVE_DELAY, 60: frame ticks between serve setup and release; must be ≥1.
- RALLY_WIDTH, 8: width of the rally counter.

- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-high reset.
- frame_tick  in  1  one-cycle pulse per video frame.
- start  in  1  level; sampled only in IDLE and GAME_OVER.
- goal_left  in  1  one-cycle pulse: ball passed player1's paddle line.
- goal_right  in  1  one-cycle pulse: ball passed player2's paddle line.
- paddle_hit  in  1  one-cycle pulse: ball bounced off either paddle.
- ball_reset  out  1  hold ball at centre.
- ball_enable  out  1  ball may move.
- serve_dir  out  1  0 = serve toward player1 (left), 1 = toward player2 (right).
- score1, score2  out  SCORE_WIDTH  player scores.
- rally_count  out  RALLY_WIDTH  paddle hits in the current rally; saturates at all-ones.
- game_over  out  1  match finished.
- winner  out  1  0 = player1, 1 = player2; valid only while game_over=1.

## Operation
- States: IDLE, SERVE_WAIT, PLAY, POINT, GAME_OVER.
- Outputs decoded from the registered state (Moore):
  - ball_reset=1 in IDLE, SERVE_WAIT, POINT and GAME_OVER.
  - ball_enable=1 only in PLAY.
  - game_over=1 only in GAME_OVER.
- IDLE: if start=1 → SERVE_WAIT; clear scores and rally; serve_dir=1.
- SERVE_WAIT:
  - Serve counter is cleared on entry and increments on each frame_tick.
  - On the frame_tick where counter==SERVE_DELAY-1 → PLAY.
  - Goal and paddle_hit inputs are ignored.
- PLAY:
  - goal_left: score2+1.
  - Otherwise goal_right: score1+1.
  - Either goal → POINT.
  - goal_left has priority if both goals are asserted in the same cycle; exactly one point is awarded.
  - paddle_hit: rally_count+1, saturating.
  - If paddle_hit coincides with a goal, the goal is taken and rally is not incremented.
  - start is ignored.
- POINT, one cycle:
  - If the scorer's score == WIN_SCORE → GAME_OVER, winner=scorer.
  - Otherwise → SERVE_WAIT, serve_dir toward the player who lost the point, rally_count cleared.
- GAME_OVER:
  - Scores, winner and rally_count held.
  - start=1 → SERVE_WAIT; clear scores and rally; serve_dir=1; winner=0.
- Scores never exceed WIN_SCORE, so no wrap is possible.

## Timing
- Reset values: state=IDLE, score1=score2=0, rally_count=0, serve_dir=1, winner=0, game_over=0, ball_reset=1, ball_enable=0.
- Reset asserted mid-match returns all of the above immediately (asynchronously), regardless of state.
- Goal pulse at cycle N in PLAY:
  - N+1: score updated, state=POINT, ball_enable=0.
  - N+2: state=SERVE_WAIT or GAME_OVER; serve_dir/winner valid.
- Start sampled at edge N in IDLE: SERVE_WAIT at N+1.
- Serve release:
  - PLAY begins the cycle after the SERVE_DELAY-th frame_tick counted in SERVE_WAIT.
  - A frame_tick on the entry cycle is not counted.
- paddle_hit at N in PLAY: rally_count updated at N+1.
- Event pulses arriving outside PLAY have no effect and are not queued.

## Structure
- Shared package pong_pkg:
  - state enum match_state_t (IDLE, SERVE_WAIT, PLAY, POINT, GAME_OVER).
  - Direction constants DIR_LEFT=0, DIR_RIGHT=1.
  - Player constants P1=0, P2=1.
  - Defaults for WIN_SCORE and SERVE_DELAY.
- One sub-module, serve_timer:
  - Frame-tick counter with clear input and a done output.
  - Parameterised by SERVE_DELAY, with counter width sized by $clog2.
- FSM, score registers and rally counter stay in match_controller.

## Test plan
- Reset, then start=1 for 1 cycle → SERVE_WAIT next cycle, scores 0/0, serve_dir=1; after 60 frame_ticks → ball_enable=1 one cycle later.
- In PLAY, pulse goal_right → score1=1, POINT for one cycle, then SERVE_WAIT with serve_dir=1 (toward player2) and rally_count=0.
- In PLAY, 3 paddle_hit pulses then goal_left coincident with paddle_hit → rally_count=3 at POINT, score2=1, serve_dir=0.
- Same-cycle goal_left and goal_right → only score2 increments.
- Player1 scores 7 goals (WIN_SCORE=7) → GAME_OVER, winner=0, score1=7; extra goal pulses ignored; start → scores 0/0, SERVE_WAIT.
- Assert rst while in PLAY with score 3/2 → outputs return to reset values immediately.
- Pulse goal_left during SERVE_WAIT and POINT → scores unchanged.
- Drive 300 paddle_hits with RALLY_WIDTH=8 → rally_count holds 255.

Source files
------------

// File: rtl/pong_pkg.sv
// Shared types and constants for the pong game-flow logic.
package pong_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SERVE_WAIT,
        PLAY,
        POINT,
        GAME_OVER
    } match_state_t;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;
    localparam logic P1        = 1'b0;
    localparam logic P2        = 1'b1;

    localparam int DEFAULT_WIN_SCORE   = 7;
    localparam int DEFAULT_SERVE_DELAY = 60;

endpackage

// File: rtl/serve_timer.sv
// Counts frame ticks while enabled; done pulses on the tick that completes the delay.
module serve_timer
    import pong_pkg::*;
#(
    parameter int SERVE_DELAY = DEFAULT_SERVE_DELAY
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic tick_i,
    output logic done_o
);

    localparam int CW = (SERVE_DELAY > 1) ? $clog2(SERVE_DELAY) : 1;
    localparam logic [CW-1:0] LAST = CW'(SERVE_DELAY - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (tick_i) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done_o = !clear_i && tick_i && (cnt_q == LAST);

endmodule

// File: rtl/match_controller.sv
// Match sequencing for pong: serve delay, rally tracking, scoring and game over.
module match_controller
    import pong_pkg::*;
#(
    parameter int SCORE_WIDTH = 4,
    parameter int WIN_SCORE   = DEFAULT_WIN_SCORE,
    parameter int SERVE_DELAY = DEFAULT_SERVE_DELAY,
    parameter int RALLY_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   frame_tick,
    input  logic                   start,
    input  logic                   goal_left,
    input  logic                   goal_right,
    input  logic                   paddle_hit,
    output logic                   ball_reset,
    output logic                   ball_enable,
    output logic                   serve_dir,
    output logic [SCORE_WIDTH-1:0] score1,
    output logic [SCORE_WIDTH-1:0] score2,
    output logic [RALLY_WIDTH-1:0] rally_count,
    output logic                   game_over,
    output logic                   winner
);

    localparam logic [SCORE_WIDTH-1:0] WIN       = SCORE_WIDTH'(WIN_SCORE);
    localparam logic [RALLY_WIDTH-1:0] RALLY_MAX = {RALLY_WIDTH{1'b1}};

    match_state_t           state_q, state_d;
    logic [SCORE_WIDTH-1:0] score1_q, score1_d;
    logic [SCORE_WIDTH-1:0] score2_q, score2_d;
    logic [RALLY_WIDTH-1:0] rally_q, rally_d;
    logic                   serve_dir_q, serve_dir_d;
    logic                   winner_q, winner_d;
    logic                   scorer_q, scorer_d;
    logic                   timer_clear;
    logic                   serve_done;
    logic [SCORE_WIDTH-1:0] scorer_score;

    serve_timer #(
        .SERVE_DELAY(SERVE_DELAY)
    ) u_serve_timer (
        .clk    (clk),
        .rst    (rst),
        .clear_i(timer_clear),
        .tick_i (frame_tick),
        .done_o (serve_done)
    );

    // Holding the timer clear outside SERVE_WAIT means every entry starts from zero.
    assign timer_clear  = (state_q != SERVE_WAIT);
    assign scorer_score = (scorer_q == P2) ? score2_q : score1_q;

    always_comb begin
        state_d     = state_q;
        score1_d    = score1_q;
        score2_d    = score2_q;
        rally_d     = rally_q;
        serve_dir_d = serve_dir_q;
        winner_d    = winner_q;
        scorer_d    = scorer_q;
        case (state_q)
            IDLE, GAME_OVER: begin
                if (start) begin
                    state_d     = SERVE_WAIT;
                    score1_d    = '0;
                    score2_d    = '0;
                    rally_d     = '0;
                    serve_dir_d = DIR_RIGHT;
                    winner_d    = P1;
                end
            end
            SERVE_WAIT: begin
                if (serve_done) begin
                    state_d = PLAY;
                end
            end
            PLAY: begin
                if (goal_left) begin
                    score2_d = score2_q + SCORE_WIDTH'(1);
                    scorer_d = P2;
                    state_d  = POINT;
                end else if (goal_right) begin
                    score1_d = score1_q + SCORE_WIDTH'(1);
                    scorer_d = P1;
                    state_d  = POINT;
                end else if (paddle_hit && (rally_q != RALLY_MAX)) begin
                    rally_d = rally_q + RALLY_WIDTH'(1);
                end
            end
            POINT: begin
                if (scorer_score == WIN) begin
                    state_d  = GAME_OVER;
                    winner_d = scorer_q;
                end else begin
                    // The player who lost the point receives the next serve.
                    state_d     = SERVE_WAIT;
                    serve_dir_d = (scorer_q == P2) ? DIR_LEFT : DIR_RIGHT;
                    rally_d     = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            score1_q    <= '0;
            score2_q    <= '0;
            rally_q     <= '0;
            serve_dir_q <= DIR_RIGHT;
            winner_q    <= P1;
            scorer_q    <= P1;
        end else begin
            state_q     <= state_d;
            score1_q    <= score1_d;
            score2_q    <= score2_d;
            rally_q     <= rally_d;
            serve_dir_q <= serve_dir_d;
            winner_q    <= winner_d;
            scorer_q    <= scorer_d;
        end
    end

    assign ball_reset  = (state_q != PLAY);
    assign ball_enable = (state_q == PLAY);
    assign game_over   = (state_q == GAME_OVER);
    assign serve_dir   = serve_dir_q;
    assign score1      = score1_q;
    assign score2      = score2_q;
    assign rally_count = rally_q;
    assign winner      = winner_q;

endmodule

// File: tb/tb_match_controller.sv
// Directed bench for match_controller: serve timing, scoring, win, reset and saturation.
module tb_match_controller;
    import pong_pkg::*;

    localparam int SD = 60;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       frame_tick = 1'b0;
    logic       start = 1'b0;
    logic       goal_left = 1'b0;
    logic       goal_right = 1'b0;
    logic       paddle_hit = 1'b0;
    logic       ball_reset, ball_enable, serve_dir, game_over, winner;
    logic [3:0] score1, score2;
    logic [7:0] rally_count;

    int checks = 0;
    int failures = 0;

    match_controller #(
        .SCORE_WIDTH(4), .WIN_SCORE(7), .SERVE_DELAY(SD), .RALLY_WIDTH(8)
    ) dut (
        .clk(clk), .rst(rst), .frame_tick(frame_tick), .start(start),
        .goal_left(goal_left), .goal_right(goal_right), .paddle_hit(paddle_hit),
        .ball_reset(ball_reset), .ball_enable(ball_enable), .serve_dir(serve_dir),
        .score1(score1), .score2(score2), .rally_count(rally_count),
        .game_over(game_over), .winner(winner)
    );

    always #5 clk = ~clk;

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            frame_tick = 1'b1;
            @(negedge clk);
        end
        frame_tick = 1'b0;
    endtask

    task automatic pulse(input logic l, input logic r, input logic h);
        goal_left = l; goal_right = r; paddle_hit = h;
        @(negedge clk);
        goal_left = 1'b0; goal_right = 1'b0; paddle_hit = 1'b0;
    endtask

    task automatic go_play();
        @(negedge clk);
        ticks(SD);
    endtask

    task automatic press_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (ball_reset !== 1'b1) begin failures++; $display("FAIL reset_ball_reset got=%0b exp=1", ball_reset); end
        checks++; if (ball_enable !== 1'b0) begin failures++; $display("FAIL reset_ball_enable got=%0b exp=0", ball_enable); end
        checks++; if (serve_dir !== 1'b1) begin failures++; $display("FAIL reset_serve_dir got=%0b exp=1", serve_dir); end
        checks++; if ({score1, score2, rally_count} !== 16'h0) begin failures++; $display("FAIL reset_counts got=%0d/%0d/%0d exp=0/0/0", score1, score2, rally_count); end
        checks++; if ({game_over, winner} !== 2'b00) begin failures++; $display("FAIL reset_over_winner got=%0b%0b exp=00", game_over, winner); end
        rst = 1'b0;
        @(negedge clk);
        checks++; if (dut.state_q !== IDLE) begin failures++; $display("FAIL idle_hold got=%0d exp=%0d", dut.state_q, IDLE); end
        $display("test_reset done");
    endtask

    task automatic test_start_serve();
        start = 1'b1; frame_tick = 1'b1;
        @(negedge clk);
        start = 1'b0; frame_tick = 1'b0;
        checks++; if (dut.state_q !== SERVE_WAIT) begin failures++; $display("FAIL start_state got=%0d exp=%0d", dut.state_q, SERVE_WAIT); end
        checks++; if (serve_dir !== 1'b1 || score1 !== 4'd0 || score2 !== 4'd0) begin failures++; $display("FAIL start_outputs got=%0b %0d/%0d exp=1 0/0", serve_dir, score1, score2); end
        go_play();
        checks++; if (ball_enable !== 1'b1 || ball_reset !== 1'b0) begin failures++; $display("FAIL serve_release got=%0b%0b exp=10", ball_enable, ball_reset); end
        $display("test_start_serve done");
    endtask

    task automatic test_serve_boundary();
        pulse(1'b0, 1'b1, 1'b0);
        @(negedge clk);
        @(negedge clk);
        ticks(SD - 1);
        checks++; if (ball_enable !== 1'b0) begin failures++; $display("FAIL serve_early got=%0b exp=0", ball_enable); end
        ticks(1);
        checks++; if (ball_enable !== 1'b1) begin failures++; $display("FAIL serve_exact got=%0b exp=1", ball_enable); end
        $display("test_serve_boundary done score=%0d/%0d", score1, score2);
    endtask

    task automatic test_goal_right();
        pulse(1'b0, 1'b1, 1'b0);
        checks++; if (score1 !== 4'd2 || score2 !== 4'd0) begin failures++; $display("FAIL goal_right_score got=%0d/%0d exp=2/0", score1, score2); end
        checks++; if (dut.state_q !== POINT || ball_enable !== 1'b0) begin failures++; $display("FAIL goal_right_point got=%0d,%0b exp=%0d,0", dut.state_q, ball_enable, POINT); end
        @(negedge clk);
        checks++; if (dut.state_q !== SERVE_WAIT || serve_dir !== 1'b1 || rally_count !== 8'd0) begin failures++; $display("FAIL goal_right_serve got=%0d,%0b,%0d exp=%0d,1,0", dut.state_q, serve_dir, rally_count, SERVE_WAIT); end
        $display("test_goal_right done");
    endtask

    task automatic test_rally_goal_left();
        go_play();
        repeat (3) pulse(1'b0, 1'b0, 1'b1);
        checks++; if (rally_count !== 8'd3) begin failures++; $display("FAIL rally_three got=%0d exp=3", rally_count); end
        pulse(1'b1, 1'b0, 1'b1);
        checks++; if (rally_count !== 8'd3 || score2 !== 4'd1 || score1 !== 4'd2) begin failures++; $display("FAIL goal_left_hit got=%0d,%0d/%0d exp=3,2/1", rally_count, score1, score2); end
        checks++; if (dut.state_q !== POINT) begin failures++; $display("FAIL goal_left_point got=%0d exp=%0d", dut.state_q, POINT); end
        @(negedge clk);
        checks++; if (serve_dir !== 1'b0 || rally_count !== 8'd0) begin failures++; $display("FAIL goal_left_serve got=%0b,%0d exp=0,0", serve_dir, rally_count); end
        $display("test_rally_goal_left done");
    endtask

    task automatic test_ignore_events();
        pulse(1'b1, 1'b0, 1'b0);
        pulse(1'b0, 1'b1, 1'b1);
        checks++; if (score1 !== 4'd2 || score2 !== 4'd1 || rally_count !== 8'd0 || dut.state_q !== SERVE_WAIT) begin failures++; $display("FAIL ignore_serve_wait got=%0d/%0d,%0d,%0d exp=2/1,0,%0d", score1, score2, rally_count, dut.state_q, SERVE_WAIT); end
        go_play();
        pulse(1'b0, 1'b1, 1'b0);
        checks++; if (score1 !== 4'd3 || dut.state_q !== POINT) begin failures++; $display("FAIL ignore_setup got=%0d,%0d exp=3,%0d", score1, dut.state_q, POINT); end
        pulse(1'b1, 1'b0, 1'b0);
        checks++; if (score1 !== 4'd3 || score2 !== 4'd1 || dut.state_q !== SERVE_WAIT || serve_dir !== 1'b1) begin failures++; $display("FAIL ignore_point got=%0d/%0d,%0d,%0b exp=3/1,%0d,1", score1, score2, dut.state_q, serve_dir, SERVE_WAIT); end
        $display("test_ignore_events done");
    endtask

    task automatic test_double_goal();
        go_play();
        pulse(1'b1, 1'b1, 1'b0);
        checks++; if (score1 !== 4'd3 || score2 !== 4'd2) begin failures++; $display("FAIL double_goal got=%0d/%0d exp=3/2", score1, score2); end
        @(negedge clk);
        checks++; if (serve_dir !== 1'b0) begin failures++; $display("FAIL double_goal_dir got=%0b exp=0", serve_dir); end
        $display("test_double_goal done");
    endtask

    task automatic test_win_p1();
        for (int i = 0; i < 4; i++) begin
            go_play();
            pulse(1'b0, 1'b0, 1'b1);
            pulse(1'b0, 1'b1, 1'b0);
            checks++; if (score1 !== 4'(4 + i)) begin failures++; $display("FAIL win_p1_score got=%0d exp=%0d", score1, 4 + i); end
            @(negedge clk);
            if (i < 3) begin
                checks++; if (game_over !== 1'b0) begin failures++; $display("FAIL win_p1_early got=%0b exp=0 at %0d", game_over, score1); end
            end
        end
        checks++; if (game_over !== 1'b1 || winner !== 1'b0 || dut.state_q !== GAME_OVER) begin failures++; $display("FAIL win_p1_over got=%0b,%0b,%0d exp=1,0,%0d", game_over, winner, dut.state_q, GAME_OVER); end
        checks++; if (score1 !== 4'd7 || score2 !== 4'd2 || rally_count !== 8'd1 || ball_reset !== 1'b1) begin failures++; $display("FAIL win_p1_hold got=%0d/%0d,%0d,%0b exp=7/2,1,1", score1, score2, rally_count, ball_reset); end
        pulse(1'b1, 1'b0, 1'b0);
        pulse(1'b0, 1'b1, 1'b1);
        checks++; if (score1 !== 4'd7 || score2 !== 4'd2 || game_over !== 1'b1) begin failures++; $display("FAIL win_p1_ignore got=%0d/%0d,%0b exp=7/2,1", score1, score2, game_over); end
        press_start();
        checks++; if (score1 !== 4'd0 || score2 !== 4'd0 || dut.state_q !== SERVE_WAIT || game_over !== 1'b0 || serve_dir !== 1'b1) begin failures++; $display("FAIL win_p1_restart got=%0d/%0d,%0d,%0b,%0b exp=0/0,%0d,0,1", score1, score2, dut.state_q, game_over, serve_dir, SERVE_WAIT); end
        $display("test_win_p1 done");
    endtask

    task automatic test_win_p2();
        for (int i = 0; i < 7; i++) begin
            go_play();
            pulse(1'b1, 1'b0, 1'b0);
            @(negedge clk);
        end
        checks++; if (game_over !== 1'b1 || winner !== 1'b1 || score2 !== 4'd7 || score1 !== 4'd0) begin failures++; $display("FAIL win_p2_over got=%0b,%0b,%0d/%0d exp=1,1,0/7", game_over, winner, score1, score2); end
        press_start();
        checks++; if (winner !== 1'b0 || serve_dir !== 1'b1 || score2 !== 4'd0) begin failures++; $display("FAIL win_p2_restart got=%0b,%0b,%0d exp=0,1,0", winner, serve_dir, score2); end
        $display("test_win_p2 done");
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 5; i++) begin
            go_play();
            pulse(i >= 3, i < 3, 1'b0);
            @(negedge clk);
        end
        go_play();
        pulse(1'b0, 1'b0, 1'b1);
        checks++; if (ball_enable !== 1'b1 || score1 !== 4'd3 || score2 !== 4'd2 || rally_count !== 8'd1) begin failures++; $display("FAIL async_setup got=%0b,%0d/%0d,%0d exp=1,3/2,1", ball_enable, score1, score2, rally_count); end
        #2 rst = 1'b1;
        #1;
        checks++; if (ball_enable !== 1'b0 || ball_reset !== 1'b1 || dut.state_q !== IDLE) begin failures++; $display("FAIL async_state got=%0b%0b,%0d exp=01,%0d", ball_enable, ball_reset, dut.state_q, IDLE); end
        checks++; if (score1 !== 4'd0 || score2 !== 4'd0 || rally_count !== 8'd0 || serve_dir !== 1'b1 || winner !== 1'b0 || game_over !== 1'b0) begin failures++; $display("FAIL async_values got=%0d/%0d,%0d,%0b,%0b,%0b exp=0/0,0,1,0,0", score1, score2, rally_count, serve_dir, winner, game_over); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        $display("test_async_reset done");
    endtask

    task automatic test_rally_saturate();
        press_start();
        go_play();
        paddle_hit = 1'b1;
        repeat (100) @(negedge clk);
        checks++; if (rally_count !== 8'd100) begin failures++; $display("FAIL rally_100 got=%0d exp=100", rally_count); end
        repeat (200) @(negedge clk);
        paddle_hit = 1'b0;
        checks++; if (rally_count !== 8'd255 || ball_enable !== 1'b1) begin failures++; $display("FAIL rally_sat got=%0d,%0b exp=255,1", rally_count, ball_enable); end
        $display("test_rally_saturate done");
    endtask

    initial begin
        test_reset();
        test_start_serve();
        test_serve_boundary();
        test_goal_right();
        test_rally_goal_left();
        test_ignore_events();
        test_double_goal();
        test_win_p1();
        test_win_p2();
        test_async_reset();
        test_rally_saturate();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
